kmer_extractor: RTL

- Upstream stage of the 2-entry k-mer window buffer.
- Consumes a stream of 2-bit encoded bases, one per handshake, and assembles a sliding K-base k-mer in a shift register.
- Writes each complete k-mer into a ping-pong slot of the window buffer.
- Tracks slot occupancy so the downstream consumer reads a slot only after it is written, and releases it explicitly.

---
 rtl/kmer_extractor_pkg.sv | 17 +
 rtl/kmer_slot_tracker.sv | 53 +++++
 rtl/kmer_extractor.sv | 99 +++++++++
 3 files changed

// File: rtl/kmer_extractor_pkg.sv
// Shared parameters, base encodings and k-mer payload type for the k-mer path.
package kmer_extractor_pkg;

    localparam int unsigned K      = 60;
    localparam int unsigned BASE_W = 2;
    localparam int unsigned KMER_W = K * BASE_W;
    localparam int unsigned CNT_W  = 6;

    localparam logic [BASE_W-1:0] BASE_A = 2'b00;
    localparam logic [BASE_W-1:0] BASE_C = 2'b01;
    localparam logic [BASE_W-1:0] BASE_G = 2'b10;
    localparam logic [BASE_W-1:0] BASE_T = 2'b11;

    // Shared with the window buffer: one complete k-mer, oldest base in the MSBs.
    typedef logic [KMER_W-1:0] kmer_t;

endpackage

// File: rtl/kmer_slot_tracker.sv
// Ping-pong slot occupancy for the 2-entry window buffer.
// The write pointer advances when an emission is decided; the full bit is set
// one cycle later, together with the buffer write, so the reader never sees a
// slot before its data has landed.
module kmer_slot_tracker (
    input  logic clk,
    input  logic rst,
    input  logic i_emit,
    input  logic i_commit,
    input  logic i_commit_addr,
    input  logic i_commit_last,
    input  logic i_consume,
    output logic o_wptr,
    output logic o_slot_free,
    output logic o_kmer_valid,
    output logic o_kmer_raddr,
    output logic o_kmer_last
);

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_full;
    logic [1:0] r_last_flag;

    // Pointer and occupancy update; consume and commit never target the same live slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_full      <= 2'b00;
            r_last_flag <= 2'b00;
        end else begin
            if (i_emit) begin
                r_wptr <= ~r_wptr;
            end
            if (i_consume && r_full[r_rptr]) begin
                r_full[r_rptr] <= 1'b0;
                r_rptr         <= ~r_rptr;
            end
            if (i_commit) begin
                r_full[i_commit_addr]      <= 1'b1;
                r_last_flag[i_commit_addr] <= i_commit_last;
            end
        end
    end

    assign o_wptr       = r_wptr;
    assign o_slot_free  = ~r_full[r_wptr];
    assign o_kmer_valid = r_full[r_rptr];
    assign o_kmer_raddr = r_rptr;
    assign o_kmer_last  = r_last_flag[r_rptr];

endmodule

// File: rtl/kmer_extractor.sv
// Assembles a sliding K-base k-mer from a 2-bit base stream and writes each
// complete k-mer into the next ping-pong slot of the window buffer.
module kmer_extractor
    import kmer_extractor_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              base_valid,
    output logic              base_ready,
    input  logic [BASE_W-1:0] base_code,
    input  logic              base_is_n,
    input  logic              base_last,
    output logic              win_wen,
    output logic              win_waddr,
    output logic [KMER_W-1:0] win_wdata,
    output logic              kmer_valid,
    output logic              kmer_raddr,
    output logic              kmer_last,
    input  logic              kmer_consume,
    output logic [31:0]       kmer_total
);

    kmer_t            r_sreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_win_wen;
    logic             r_win_waddr;
    kmer_t            r_win_wdata;
    logic             r_win_last;
    logic [31:0]      r_total;

    logic  w_accept;
    logic  w_emit;
    logic  w_cnt_full;
    logic  w_wptr;
    logic  w_slot_free;
    kmer_t w_sreg_next;

    assign w_cnt_full  = (r_cnt >= CNT_W'(K - 1));
    assign base_ready  = w_slot_free || !w_cnt_full;
    assign w_accept    = base_valid && base_ready;
    assign w_emit      = w_accept && !base_is_n && w_cnt_full;
    assign w_sreg_next = {r_sreg[KMER_W-BASE_W-1:0], base_code};

    // Shift register and run-length counter; N or end-of-read restarts the k-mer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            if (base_is_n || base_last) begin
                r_sreg <= '0;
                r_cnt  <= '0;
            end else begin
                r_sreg <= w_sreg_next;
                r_cnt  <= (r_cnt == CNT_W'(K)) ? r_cnt : r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered window write plus the end-of-read flag that travels with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_wen   <= 1'b0;
            r_win_waddr <= 1'b0;
            r_win_wdata <= '0;
            r_win_last  <= 1'b0;
            r_total     <= '0;
        end else begin
            r_win_wen <= w_emit;
            if (w_emit) begin
                r_win_waddr <= w_wptr;
                r_win_wdata <= w_sreg_next;
                r_win_last  <= base_last;
                r_total     <= r_total + 32'd1;
            end
        end
    end

    kmer_slot_tracker u_slot_tracker (
        .clk           (clk),
        .rst           (rst),
        .i_emit        (w_emit),
        .i_commit      (r_win_wen),
        .i_commit_addr (r_win_waddr),
        .i_commit_last (r_win_last),
        .i_consume     (kmer_consume),
        .o_wptr        (w_wptr),
        .o_slot_free   (w_slot_free),
        .o_kmer_valid  (kmer_valid),
        .o_kmer_raddr  (kmer_raddr),
        .o_kmer_last   (kmer_last)
    );

    assign win_wen    = r_win_wen;
    assign win_waddr  = r_win_waddr;
    assign win_wdata  = r_win_wdata;
    assign kmer_total = r_total;

endmodule
